// File: rtl/common_types_pkg.sv
// Shared AHB-Lite types: HTRANS codes, data-phase select encoding and the
// default-satellite state type.
package common_types_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Select encoding is sized for the largest supported satellite count (8).
    // MSB set: SAT[idx] in the low bits; MSB clear: 0 = NONE, 1 = DEFAULT.
    localparam int unsigned MAX_SAT   = 8;
    localparam int unsigned SAT_IDX_W = $clog2(MAX_SAT);

    typedef logic [SAT_IDX_W:0] dsel_t;

    localparam dsel_t DSEL_NONE    = dsel_t'(0);
    localparam dsel_t DSEL_DEFAULT = dsel_t'(1);

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_t;

    function automatic dsel_t dsel_sat(input logic [SAT_IDX_W-1:0] idx);
        return {1'b1, idx};
    endfunction

    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_satellite.sv
// Default satellite: answers every unmapped transfer with a two-cycle ERROR
// and keeps a saturating count of the errors it has issued.
module ahb_default_satellite
    import common_types_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       sel,        // current address phase targets DEFAULT
    input  logic       hready_in,  // address phase is accepted this cycle
    output logic       hreadyout,
    output logic       hresp,
    output logic [7:0] err_cnt
);

    ds_state_t state, state_nxt;
    logic      accept;

    assign accept = sel && hready_in;

    // State register; reset drops any error in progress.
    always_ff @(posedge clk) begin
        if (!nrst) state <= DS_IDLE;
        else       state <= state_nxt;
    end

    // Next state and response outputs; ERR1 stalls, ERR2 completes the error.
    always_comb begin
        state_nxt = state;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state)
            DS_IDLE: begin
                if (accept) state_nxt = DS_ERR1;
            end
            DS_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_nxt = DS_ERR2;
            end
            DS_ERR2: begin
                hresp     = 1'b1;
                state_nxt = accept ? DS_ERR1 : DS_IDLE;
            end
            default: state_nxt = DS_IDLE;
        endcase
    end

    // Error counter: one count per completed error, sticks at 8'hFF.
    always_ff @(posedge clk) begin
        if (!nrst)                                  err_cnt <= 8'h00;
        else if (state == DS_ERR2 && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end

endmodule

// File: rtl/ahb_lite_decoder_mux.sv
// AHB-Lite address decoder and response multiplexer with a built-in default
// satellite for unmapped accesses.
module ahb_lite_decoder_mux
    import common_types_pkg::*;
#(
    parameter int unsigned                  NUM_SAT  = 4,
    parameter logic [NUM_SAT-1:0][31:0]     SAT_BASE = {32'h3000_0000, 32'h2000_0000,
                                                        32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SAT-1:0][31:0]     SAT_MASK = {32'hF000_0000, 32'hF000_0000,
                                                        32'hF000_0000, 32'hF000_0000}
)
(
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [31:0]             c_haddr,
    input  logic [1:0]              c_htrans,
    input  logic                    c_hwrite,
    input  logic [2:0]              c_hsize,
    input  logic [2:0]              c_hburst,
    input  logic [31:0]             c_hwdata,
    output logic [31:0]             c_hrdata,
    output logic                    c_hready,
    output logic                    c_hresp,
    output logic [NUM_SAT-1:0]      s_hsel,
    output logic [31:0]             s_haddr,
    output logic [1:0]              s_htrans,
    output logic                    s_hwrite,
    output logic [2:0]              s_hsize,
    output logic [2:0]              s_hburst,
    output logic [31:0]             s_hwdata,
    output logic                    s_hready,
    input  logic [NUM_SAT*32-1:0]   s_hrdata,
    input  logic [NUM_SAT-1:0]      s_hreadyout,
    input  logic [NUM_SAT-1:0]      s_hresp,
    output logic [7:0]              err_cnt
);

    logic                 addr_hit;
    logic [SAT_IDX_W-1:0] addr_win;
    dsel_t                addr_tgt;
    dsel_t                dsel;
    logic                 ds_hreadyout;
    logic                 ds_hresp;

    // Address decode; scanning from the top down lets the lowest index win.
    always_comb begin
        addr_hit = 1'b0;
        addr_win = '0;
        s_hsel   = '0;
        for (int i = int'(NUM_SAT) - 1; i >= 0; i--) begin
            if ((c_haddr & SAT_MASK[i]) == SAT_BASE[i]) begin
                addr_hit  = 1'b1;
                addr_win  = SAT_IDX_W'(i);
                s_hsel    = '0;
                s_hsel[i] = 1'b1;
            end
        end
    end

    // Address-phase target: only real transfers reach a satellite or DEFAULT.
    always_comb begin
        addr_tgt = DSEL_NONE;
        if (htrans_active(c_htrans))
            addr_tgt = addr_hit ? dsel_sat(addr_win) : DSEL_DEFAULT;
    end

    // Data-phase select follows the address phase only when it is accepted.
    always_ff @(posedge clk) begin
        if (!nrst)         dsel <= DSEL_NONE;
        else if (c_hready) dsel <= addr_tgt;
    end

    ahb_default_satellite u_default (
        .clk       (clk),
        .nrst      (nrst),
        .sel       (addr_tgt == DSEL_DEFAULT),
        .hready_in (c_hready),
        .hreadyout (ds_hreadyout),
        .hresp     (ds_hresp),
        .err_cnt   (err_cnt)
    );

    // Response mux; NONE is a zero-wait OKAY with zero read data.
    always_comb begin
        c_hrdata = '0;
        c_hready = 1'b1;
        c_hresp  = 1'b0;
        if (dsel == DSEL_DEFAULT) begin
            c_hready = ds_hreadyout;
            c_hresp  = ds_hresp;
        end else begin
            for (int i = 0; i < int'(NUM_SAT); i++) begin
                if (dsel == dsel_sat(SAT_IDX_W'(i))) begin
                    c_hrdata = s_hrdata[i*32 +: 32];
                    c_hready = s_hreadyout[i];
                    c_hresp  = s_hresp[i];
                end
            end
        end
    end

    assign s_haddr  = c_haddr;
    assign s_htrans = c_htrans;
    assign s_hwrite = c_hwrite;
    assign s_hsize  = c_hsize;
    assign s_hburst = c_hburst;
    assign s_hwdata = c_hwdata;
    assign s_hready = c_hready;

endmodule

// File: tb/tb_ahb_lite_decoder_mux.sv
// Directed bench for ahb_lite_decoder_mux with a response scoreboard.
module tb_ahb_lite_decoder_mux;
    import common_types_pkg::*;

    localparam int NS = 4;

    logic            clk;
    logic            nrst;
    logic [31:0]     c_haddr;
    logic [1:0]      c_htrans;
    logic            c_hwrite;
    logic [2:0]      c_hsize;
    logic [2:0]      c_hburst;
    logic [31:0]     c_hwdata;
    logic [31:0]     c_hrdata;
    logic            c_hready;
    logic            c_hresp;
    logic [NS-1:0]   s_hsel;
    logic [31:0]     s_haddr;
    logic [1:0]      s_htrans;
    logic            s_hwrite;
    logic [2:0]      s_hsize;
    logic [2:0]      s_hburst;
    logic [31:0]     s_hwdata;
    logic            s_hready;
    logic [NS*32-1:0] s_hrdata;
    logic [NS-1:0]   s_hreadyout;
    logic [NS-1:0]   s_hresp;
    logic [7:0]      err_cnt;

    ahb_lite_decoder_mux dut (
        .clk(clk), .nrst(nrst),
        .c_haddr(c_haddr), .c_htrans(c_htrans), .c_hwrite(c_hwrite),
        .c_hsize(c_hsize), .c_hburst(c_hburst), .c_hwdata(c_hwdata),
        .c_hrdata(c_hrdata), .c_hready(c_hready), .c_hresp(c_hresp),
        .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans),
        .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
        .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hrdata(s_hrdata),
        .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        rdy;
        logic        resp;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_rsp(input string tag, input logic rdy, input logic resp,
                              input logic [31:0] rdata);
        rsp_t e;
        e.tag = tag; e.rdy = rdy; e.resp = resp; e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Compare the pending data-phase expectations at the falling edge, then
    // advance to just after the next rising edge.
    task automatic tick();
        rsp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".hready"},   {31'b0, c_hready}, {31'b0, e.rdy});
            check({e.tag, ".hresp"},    {31'b0, c_hresp},  {31'b0, e.resp});
            check({e.tag, ".hrdata"},   c_hrdata,          e.rdata);
            check({e.tag, ".s_hready"}, {31'b0, s_hready}, {31'b0, e.rdy});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [1:0] t, input logic w);
        c_haddr  = a;
        c_htrans = t;
        c_hwrite = w;
        c_hsize  = 3'b010;
        c_hburst = 3'b000;
    endtask

    task automatic sel_is(input string tag, input logic [NS-1:0] exp);
        #1;
        check(tag, {28'b0, s_hsel}, {28'b0, exp});
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst        = 1'b0;
        addr_phase(32'h0, HTRANS_IDLE, 1'b0);
        c_hwdata    = 32'h0;
        s_hreadyout = '1;
        s_hresp     = '0;
        s_hrdata    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0A0A};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        expect_rsp("reset", 1'b1, 1'b0, 32'h0);
        check("reset.err_cnt", {24'b0, err_cnt}, 32'h0);
        nrst = 1'b1;
        tick();

        // 1: read sat0 with two wait states
        addr_phase(32'h0000_0010, HTRANS_NONSEQ, 1'b0);
        sel_is("t1.hsel", 4'b0001);
        expect_rsp("t1.addr", 1'b1, 1'b0, 32'h0);
        tick();
        addr_phase(32'h0, HTRANS_IDLE, 1'b0);
        s_hreadyout[0] = 1'b0;
        expect_rsp("t1.wait1", 1'b0, 1'b0, 32'h0000_0A0A);
        tick();
        expect_rsp("t1.wait2", 1'b0, 1'b0, 32'h0000_0A0A);
        tick();
        s_hreadyout[0] = 1'b1;
        s_hrdata[31:0] = 32'hDEAD_BEEF;
        expect_rsp("t1.data", 1'b1, 1'b0, 32'hDEAD_BEEF);
        tick();
        expect_rsp("t1.none", 1'b1, 1'b0, 32'h0);
        tick();

        // 2: write sat1, read sat2, SEQ to sat3, back to back
        addr_phase(32'h1000_0004, HTRANS_NONSEQ, 1'b1);
        sel_is("t2.hsel1", 4'b0010);
        check("t2.haddr", s_haddr, 32'h1000_0004);
        expect_rsp("t2.a1", 1'b1, 1'b0, 32'h0);
        tick();
        addr_phase(32'h2000_0008, HTRANS_NONSEQ, 1'b0);
        c_hwdata = 32'hCAFE_F00D;
        sel_is("t2.hsel2", 4'b0100);
        check("t2.hwdata", s_hwdata, 32'hCAFE_F00D);
        expect_rsp("t2.d1", 1'b1, 1'b0, 32'h1111_1111);
        tick();
        addr_phase(32'h3000_000C, HTRANS_SEQ, 1'b0);
        sel_is("t2.hsel3", 4'b1000);
        expect_rsp("t2.d2", 1'b1, 1'b0, 32'h2222_2222);
        tick();
        addr_phase(32'h0, HTRANS_IDLE, 1'b0);
        expect_rsp("t2.d3", 1'b1, 1'b0, 32'h3333_3333);
        tick();

        // 3: single unmapped access
        addr_phase(32'hF000_0000, HTRANS_NONSEQ, 1'b0);
        sel_is("t3.hsel", 4'b0000);
        expect_rsp("t3.addr", 1'b1, 1'b0, 32'h0);
        tick();
        addr_phase(32'h0, HTRANS_IDLE, 1'b0);
        expect_rsp("t3.err1", 1'b0, 1'b1, 32'h0);
        check("t3.cnt0", {24'b0, err_cnt}, 32'd0);
        tick();
        expect_rsp("t3.err2", 1'b1, 1'b1, 32'h0);
        tick();
        expect_rsp("t3.after", 1'b1, 1'b0, 32'h0);
        check("t3.cnt1", {24'b0, err_cnt}, 32'd1);
        tick();

        // 4: back-to-back unmapped accesses, from a fresh reset
        nrst = 1'b0;
        expect_rsp("t4.rst", 1'b1, 1'b0, 32'h0);
        tick();
        nrst = 1'b1;
        check("t4.cnt_rst", {24'b0, err_cnt}, 32'd0);
        addr_phase(32'hF000_0000, HTRANS_NONSEQ, 1'b0);
        expect_rsp("t4.a1", 1'b1, 1'b0, 32'h0);
        tick();
        addr_phase(32'hF000_0004, HTRANS_NONSEQ, 1'b0);
        expect_rsp("t4.e1a", 1'b0, 1'b1, 32'h0);
        tick();
        expect_rsp("t4.e2a", 1'b1, 1'b1, 32'h0);
        tick();
        addr_phase(32'h0, HTRANS_IDLE, 1'b0);
        expect_rsp("t4.e1b", 1'b0, 1'b1, 32'h0);
        tick();
        expect_rsp("t4.e2b", 1'b1, 1'b1, 32'h0);
        tick();
        expect_rsp("t4.after", 1'b1, 1'b0, 32'h0);
        check("t4.cnt2", {24'b0, err_cnt}, 32'd2);
        tick();

        // 4b: 300 more errors saturate the counter
        addr_phase(32'hF000_0000, HTRANS_NONSEQ, 1'b0);
        expect_rsp("t4s.a", 1'b1, 1'b0, 32'h0);
        tick();
        for (int k = 0; k < 300; k++) begin
            expect_rsp("t4s.e1", 1'b0, 1'b1, 32'h0);
            tick();
            if (k == 299) addr_phase(32'h0, HTRANS_IDLE, 1'b0);
            expect_rsp("t4s.e2", 1'b1, 1'b1, 32'h0);
            tick();
        end
        expect_rsp("t4s.after", 1'b1, 1'b0, 32'h0);
        check("t4s.cnt_sat", {24'b0, err_cnt}, 32'h0000_00FF);
        tick();

        // 5: reset during a sat1 wait state
        addr_phase(32'h1000_0000, HTRANS_NONSEQ, 1'b0);
        expect_rsp("t5.addr", 1'b1, 1'b0, 32'h0);
        tick();
        addr_phase(32'h0, HTRANS_IDLE, 1'b0);
        s_hreadyout[1] = 1'b0;
        nrst = 1'b0;
        expect_rsp("t5.wait", 1'b0, 1'b0, 32'h1111_1111);
        tick();
        nrst = 1'b1;
        expect_rsp("t5.post", 1'b1, 1'b0, 32'h0);
        check("t5.cnt", {24'b0, err_cnt}, 32'd0);
        tick();
        s_hreadyout[1] = 1'b1;

        // 5b: reset during an error leaves no residual ERROR
        addr_phase(32'hF000_0000, HTRANS_NONSEQ, 1'b0);
        expect_rsp("t5b.addr", 1'b1, 1'b0, 32'h0);
        tick();
        addr_phase(32'h0, HTRANS_IDLE, 1'b0);
        nrst = 1'b0;
        expect_rsp("t5b.err1", 1'b0, 1'b1, 32'h0);
        tick();
        nrst = 1'b1;
        expect_rsp("t5b.post1", 1'b1, 1'b0, 32'h0);
        tick();
        expect_rsp("t5b.post2", 1'b1, 1'b0, 32'h0);
        check("t5b.cnt", {24'b0, err_cnt}, 32'd0);
        tick();

        // 6: IDLE to a mapped address selects but yields no data phase
        addr_phase(32'h1000_0000, HTRANS_IDLE, 1'b0);
        sel_is("t6.hsel", 4'b0010);
        expect_rsp("t6.addr", 1'b1, 1'b0, 32'h0);
        tick();
        addr_phase(32'h1000_0000, HTRANS_BUSY, 1'b0);
        s_hreadyout[1] = 1'b0;
        s_hresp[1]     = 1'b1;
        expect_rsp("t6.data", 1'b1, 1'b0, 32'h0);
        tick();
        expect_rsp("t6.busy", 1'b1, 1'b0, 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
